// File: rtl/divf_seq.sv
// Sequential floating-point divider: restoring radix-2 mantissa divider, one quotient bit per cycle.
// Define DIVF_RNE_EN for round-to-nearest-even; otherwise the result is truncated toward zero.
module divf_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] s,
  output logic                 div_by_zero
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int N  = MAN_W + 3;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(N);
  localparam logic [EXP_W-1:0] EONES = '1;
  localparam logic [EW-1:0]    BIAS  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0]    EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic [CW-1:0]    LAST  = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t state, state_nx;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;

  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, spec_hit;
  logic [W-1:0] spec_s;
  logic         spec_dbz;

  logic             sgn;
  logic [EW-1:0]    e;
  logic [MAN_W+1:0] r;
  logic [MAN_W:0]   d;
  logic [N-1:0]     q;
  logic [CW-1:0]    cnt;

  logic             ge;
  logic [MAN_W+1:0] rsub;

  logic [MAN_W-1:0] man;
  logic [EW-1:0]    en;
  logic [W-1:0]     norm_s;

  assign {sa, ea, ma} = a;
  assign {sb, eb, mb} = b;

  assign a_zero   = (ea == '0);
  assign b_zero   = (eb == '0);
  assign a_inf    = (ea == EONES) && (ma == '0);
  assign b_inf    = (eb == EONES) && (mb == '0);
  assign a_nan    = (ea == EONES) && (ma != '0);
  assign b_nan    = (eb == EONES) && (mb != '0);
  assign spec_hit = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;

  // Special-case result; denormals already count as zero via the exponent test.
  always_comb begin
    spec_s   = '0;
    spec_dbz = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_s = {1'b0, EONES, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (a_inf) begin
      spec_s = {sa ^ sb, EONES, {MAN_W{1'b0}}};
    end else if (b_zero) begin
      spec_s   = {sa ^ sb, EONES, {MAN_W{1'b0}}};
      spec_dbz = 1'b1;
    end else begin
      spec_s = {sa ^ sb, {(W-1){1'b0}}};
    end
  end

  assign ge   = (r >= {1'b0, d});
  assign rsub = ge ? (r - {1'b0, d}) : r;

  // Normalise the quotient, round, then clamp to infinity or flush to zero.
  always_comb begin
`ifdef DIVF_RNE_EN
    logic guard, sticky;
    logic [MAN_W:0] sum;
`endif
    man    = '0;
    en     = e;
    norm_s = '0;
    if (q[N-1]) begin
      man = q[N-2:2];
      en  = e;
`ifdef DIVF_RNE_EN
      guard  = q[1];
      sticky = q[0] | (r != '0);
`endif
    end else begin
      man = q[N-3:1];
      en  = e - EW'(1);
`ifdef DIVF_RNE_EN
      guard  = q[0];
      sticky = (r != '0);
`endif
    end
`ifdef DIVF_RNE_EN
    sum = {1'b0, man} + {{MAN_W{1'b0}}, guard & (sticky | man[0])};
    man = sum[MAN_W-1:0];
    en  = en + {{(EW-1){1'b0}}, sum[MAN_W]};
`endif
    if (!en[EW-1] && (en >= EMAX)) begin
      norm_s = {sgn, EONES, {MAN_W{1'b0}}};
    end else if (en[EW-1] || (en == '0)) begin
      norm_s = {sgn, {(W-1){1'b0}}};
    end else begin
      norm_s = {sgn, en[EXP_W-1:0], man};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = spec_hit ? DONE : DIV;
      DIV:     if (cnt == LAST) state_nx = NORM;
      NORM:    state_nx = DONE;
      DONE:    if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Specials land in DONE with s already formed; out_valid follows one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      s           <= '0;
      div_by_zero <= 1'b0;
      sgn         <= 1'b0;
      e           <= '0;
      r           <= '0;
      d           <= '0;
      q           <= '0;
      cnt         <= '0;
    end else begin
      in_ready <= (state_nx == IDLE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            sgn <= sa ^ sb;
            e   <= {2'b00, ea} - {2'b00, eb} + BIAS;
            r   <= {2'b01, ma};
            d   <= {1'b1, mb};
            cnt <= '0;
            if (spec_hit) begin
              s           <= spec_s;
              div_by_zero <= spec_dbz;
            end else begin
              div_by_zero <= 1'b0;
            end
          end
        end
        DIV: begin
          r   <= rsub << 1;
          q   <= {q[N-2:0], ge};
          cnt <= cnt + CW'(1);
        end
        NORM: begin
          s         <= norm_s;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (!out_valid)    out_valid <= 1'b1;
          else if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divf_seq.sv
// Testbench for divf_seq (binary32): directed cases plus randomized operands checked
// against an arithmetic reference model; honours DIVF_RNE_EN like the design.
module tb_divf_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic        out_valid, out_ready;
  logic        div_by_zero;
  logic [31:0] a, b, s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  divf_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .div_by_zero(div_by_zero)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Returns {special, div_by_zero, s} using integer long division of the significands.
  function automatic logic [33:0] refModel(input logic [31:0] ta, input logic [31:0] tb);
    int ea, eb, e;
    logic sg;
    logic [22:0] ma, mb, mant;
    logic [63:0] num, den, quo, rem;
    logic aZero, aInf, aNan, bZero, bInf, bNan;
    ea = int'(ta[30:23]);
    eb = int'(tb[30:23]);
    ma = ta[22:0];
    mb = tb[22:0];
    sg = ta[31] ^ tb[31];
    aZero = (ea == 0);
    bZero = (eb == 0);
    aInf  = (ea == 255) && (ma == 0);
    bInf  = (eb == 255) && (mb == 0);
    aNan  = (ea == 255) && (ma != 0);
    bNan  = (eb == 255) && (mb != 0);
    if (aNan || bNan || (aZero && bZero) || (aInf && bInf)) return {2'b10, 32'h7FC00000};
    if (aInf)          return {2'b10, sg, 8'hFF, 23'h0};
    if (bZero)         return {2'b11, sg, 8'hFF, 23'h0};
    if (aZero || bInf) return {2'b10, sg, 31'h0};
    num = {40'h0, 1'b1, ma} << 25;
    den = {40'h0, 1'b1, mb};
    quo = num / den;
    rem = num % den;
    e   = ea - eb + 127;
    if (quo[25]) begin
      mant = quo[24:2];
`ifdef DIVF_RNE_EN
      if (quo[1] && (quo[0] || rem != 0 || mant[0])) begin
        if (mant == 23'h7FFFFF) begin mant = 23'h0; e = e + 1; end
        else mant = mant + 23'd1;
      end
`endif
    end else begin
      e    = e - 1;
      mant = quo[23:1];
`ifdef DIVF_RNE_EN
      if (quo[0] && (rem != 0 || mant[0])) begin
        if (mant == 23'h7FFFFF) begin mant = 23'h0; e = e + 1; end
        else mant = mant + 23'd1;
      end
`endif
    end
    if (e >= 255) return {2'b00, sg, 8'hFF, 23'h0};
    if (e <= 0)   return {2'b00, sg, 31'h0};
    return {2'b00, sg, e[7:0], mant};
  endfunction

  function automatic logic [31:0] randOperand();
    int k;
    logic sg;
    logic [7:0] ex;
    logic [22:0] m;
    k  = $urandom_range(0, 15);
    sg = 1'($urandom_range(0, 1));
    m  = 23'($urandom);
    case (k)
      0:       ex = 8'h00;
      1:       begin ex = 8'hFF; m = 23'h0; end
      2:       begin ex = 8'hFF; m = m | 23'h1; end
      3:       ex = 8'($urandom_range(1, 4));
      4:       ex = 8'($urandom_range(250, 254));
      default: ex = 8'($urandom_range(100, 154));
    endcase
    return {sg, ex, m};
  endfunction

  task automatic sendOp(input logic [31:0] ta, input logic [31:0] tb);
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    while (!in_ready && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runOp(input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] wantS,
                       input logic wantDbz, input int wantLat, input string tag);
    int lat;
    sendOp(ta, tb);
    checkOutput({tag, "_busy"}, 32'(in_ready), 32'd0);
    waitResult(lat);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(wantLat));
    checkOutput({tag, "_s"}, s, wantS);
    checkOutput({tag, "_dbz"}, 32'(div_by_zero), 32'(wantDbz));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_vlow"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb, input string tag);
    logic [33:0] m;
    m = refModel(ta, tb);
    runOp(ta, tb, m[31:0], m[32], m[33] ? 1 : 27, tag);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_s", s, 32'h0);
    checkOutput("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    runOp(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 27, "six_div_two");
    runOp(32'hBF800000, 32'h40000000, 32'hBF000000, 1'b0, 27, "neg_half");
`ifdef DIVF_RNE_EN
    runOp(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 27, "third_rne");
`else
    runOp(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 27, "third_trunc");
`endif
    runOp(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1, "one_div_zero");
    runOp(32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1, "zero_div_zero");
    runOp(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1, "inf_div_inf");
    runOp(32'h00000000, 32'hC0000000, 32'h80000000, 1'b0, 1, "zero_div_neg");
    runOp(32'hFF800000, 32'h00000000, 32'hFF800000, 1'b0, 1, "neginf_div_zero");
    runOp(32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 27, "overflow");
    runOp(32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 27, "underflow");

    // Backpressure: result held, in_ready low, stray in_valid ignored.
    sendOp(32'h40C00000, 32'h40000000);
    waitResult(lat);
    checkOutput("bp_lat", 32'(lat), 32'd27);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid = 1'b1;
        a = 32'h3F800000;
        b = 32'h00000000;
      end
      if (i == 4) in_valid = 1'b0;
      checkOutput("bp_s", s, 32'h40400000);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_done_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_done_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("bp_pulse_ignored", 32'(out_valid), 32'd0);
    checkOutput("bp_still_idle", 32'(in_ready), 32'd1);
    applyStimulus(32'h3FC00000, 32'h3F400000, "b2b_first");
    applyStimulus(32'h41200000, 32'hC0800000, "b2b_second");

    // Reset while the divider is iterating.
    sendOp(32'h40C00000, 32'h40000000);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_s", s, 32'h0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    runOp(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 27, "after_rst");

    for (int i = 0; i < 40; i++) begin
      applyStimulus(randOperand(), randOperand(), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
